dut_cmd_responder: RTL and testbench
====================================

// Module: dut_cmd_responder
// PURPOSE
// - Slave-side responder for the dut_if master stream (cmd/adr/data sampled on posedge clk).
// - Decodes each cycle's cmd against a local 2**ADR_W x DATA_W register file.
// - Returns read data and status to the bench and to the coverage samplers.
// - Multi-cycle commands (INC, CLEAR) run a small FSM; commands arriving while busy are dropped and flagged.
// PARAMETERS
// - CMD_W   4   width of cmd
// - ADR_W   4   width of adr; register file depth = 2**ADR_W
// - DATA_W  4   width of data and of each register
// - CNT_W   16  width of statistics counters (STATS build only)
// PORTS
// - clk         in   1        clock; all state updates on posedge
// - rst         in   1        asynchronous, active-high reset
// - cmd         in   CMD_W    command from master modport
// - adr         in   ADR_W    register address
// - data        in   DATA_W   write data
// - rdata       out  DATA_W   read/INC result data
// - rvalid      out  1        one-cycle pulse: rdata valid
// - busy        out  1        FSM not IDLE; cmd sampled this edge is dropped
// - err         out  1        one-cycle pulse: illegal cmd or dropped cmd
// - cmd_count   out  CNT_W    accepted non-NOP commands, saturating
// - drop_count  out  CNT_W    commands dropped while busy, saturating
// BEHAVIOUR
// - Reset (async, rst=1)
//   - All outputs 0; state IDLE; all registers cleared to 0; clear pointer 0.
//   - Reset mid-INC or mid-CLEAR aborts immediately with no further writes.
// - Encoding: 0 NOP, 1 WRITE, 2 READ, 3 INC, 4 CLEAR; 5..15 ILLEGAL.
// - Sampling: cmd/adr/data are sampled every posedge.
//   - rvalid and err default to 0 each cycle unless set below.
//   - rdata holds its last value.
// - IDLE (sample at edge N, effects visible after edge N):
//   - NOP: no effect.
//   - WRITE: mem[adr] <= data.
//   - READ: rdata <= mem[adr]; rvalid <= 1.
//   - INC: capture adr; state <= RMW; busy <= 1.
//   - CLEAR: ptr <= 0; state <= CLR; busy <= 1.
//   - ILLEGAL: err <= 1; no state change.
// - RMW (edge N+1):
//   - mem[a] <= mem[a]+1 mod 2**DATA_W (15 wraps to 0).
//   - rdata <= incremented value; rvalid <= 1.
//   - state <= IDLE; busy <= 0.
// - CLR (edges N+1 .. N+2**ADR_W):
//   - mem[ptr] <= 0; ptr <= ptr+1.
//   - After clearing the last entry: state <= IDLE; busy <= 0.
//   - busy is high for exactly 2**ADR_W cycles.
// - While busy=1 at a sampling edge:
//   - Non-NOP cmd is dropped: err <= 1; drop_count++.
//   - NOP is ignored silently.
// - Latency: WRITE/READ 1 cycle; INC result 2 cycles; CLEAR 1+2**ADR_W cycles.
// - Same-address WRITE then READ on consecutive edges returns the new data (no bypass needed).
// - cmd_count increments on every accepted WRITE/READ/INC/CLEAR.
// - Counters saturate at 2**CNT_W-1; they never wrap.
// - Counters are cleared only by rst.
// CONFIGURATION
// - Macro DUT_CMD_RESPONDER_STATS_EN.
//   - Defined: cmd_count/drop_count logic is present as above.
//   - Undefined: no counter flops; cmd_count and drop_count are tied to 0.
//   - All other behaviour is unchanged in both builds.
// TESTING
// - Reset: assert rst mid-cycle.
//   - All outputs are 0 immediately, with no clock edge.
//   - READ adr=7 after release -> rdata=0, rvalid=1.
// - WRITE/READ: WRITE adr=3 data=9, then READ adr=3.
//   - Next cycle: rdata=9, rvalid=1 for 1 cycle.
//   - cmd_count=2.
// - INC wrap: WRITE adr=5 data=15, then INC adr=5.
//   - rdata=0, rvalid=1 two edges after INC.
//   - READ adr=5 -> 0.
// - CLEAR with drop: fill adr 0..15 with 10, then CLEAR.
//   - busy is high for 16 cycles.
//   - WRITE issued during busy -> err pulse, drop_count=1.
//   - Afterwards every READ returns 0.
// - Illegal: cmd=9 -> err=1 for 1 cycle.
//   - No register change; cmd_count unchanged.
// - Reset mid-CLEAR after 5 cycles: busy=0; all entries 0.
//   - Without STATS_EN, counters read 0 throughout.

Source files
------------

// File: rtl/dut_cmd_responder.sv
// dut_cmd_responder: slave-side responder for the dut_if master stream.
// It decodes each sampled cmd against a local 2**ADR_W x DATA_W register file.
// INC and CLEAR are multi-cycle operations. Any non-NOP command that arrives
// while one of them is running is dropped and flagged on err.
// Optional feature macro: DUT_CMD_RESPONDER_STATS_EN. When it is defined, the
// saturating cmd_count/drop_count counters are built. When it is undefined,
// both counters are tied to zero.
module dut_cmd_responder #(
    parameter int CMD_W  = 4,
    parameter int ADR_W  = 4,
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CMD_W-1:0]  cmd,
    input  logic [ADR_W-1:0]  adr,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  cmd_count,
    output logic [CNT_W-1:0]  drop_count
);

    localparam int DEPTH = 2 ** ADR_W;

    localparam logic [CMD_W-1:0]  CMD_NOP   = CMD_W'(3'd0);
    localparam logic [CMD_W-1:0]  CMD_WRITE = CMD_W'(3'd1);
    localparam logic [CMD_W-1:0]  CMD_READ  = CMD_W'(3'd2);
    localparam logic [CMD_W-1:0]  CMD_INC   = CMD_W'(3'd3);
    localparam logic [CMD_W-1:0]  CMD_CLEAR = CMD_W'(3'd4);

    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ONE  = DATA_W'(1'b1);
    localparam logic [ADR_W-1:0]  ADR_ZERO  = {ADR_W{1'b0}};
    localparam logic [ADR_W-1:0]  ADR_ONE   = ADR_W'(1'b1);
    localparam logic [ADR_W-1:0]  ADR_LAST  = {ADR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RMW  = 2'd1,
        ST_CLR  = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADR_W-1:0]  ptr_r, ptr_s;
    logic [ADR_W-1:0]  inc_adr_r, inc_adr_s;
    logic [DATA_W-1:0] rdata_r, rdata_s;
    logic              rvalid_r, rvalid_s;
    logic              busy_r;
    logic              err_r, err_s;
    logic              we_s;
    logic [ADR_W-1:0]  wadr_s;
    logic [DATA_W-1:0] wdata_s;
    logic [DATA_W-1:0] inc_val_s;

    // The increment wraps naturally at DATA_W bits, so 15 + 1 becomes 0.
    assign inc_val_s = mem_r[inc_adr_r] + DATA_ONE;

    // Next-state, register-file write port and response decode
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        inc_adr_s = inc_adr_r;
        rdata_s   = rdata_r;
        rvalid_s  = 1'b0;
        err_s     = 1'b0;
        we_s      = 1'b0;
        wadr_s    = adr;
        wdata_s   = data;
        case (state_r)
            ST_IDLE: begin
                case (cmd)
                    CMD_NOP: begin
                        state_s = ST_IDLE;
                    end
                    CMD_WRITE: begin
                        we_s = 1'b1;
                    end
                    CMD_READ: begin
                        rdata_s  = mem_r[adr];
                        rvalid_s = 1'b1;
                    end
                    CMD_INC: begin
                        inc_adr_s = adr;
                        state_s   = ST_RMW;
                    end
                    CMD_CLEAR: begin
                        ptr_s   = ADR_ZERO;
                        state_s = ST_CLR;
                    end
                    default: begin
                        err_s = 1'b1;
                    end
                endcase
            end
            ST_RMW: begin
                we_s     = 1'b1;
                wadr_s   = inc_adr_r;
                wdata_s  = inc_val_s;
                rdata_s  = inc_val_s;
                rvalid_s = 1'b1;
                state_s  = ST_IDLE;
            end
            ST_CLR: begin
                we_s    = 1'b1;
                wadr_s  = ptr_r;
                wdata_s = DATA_ZERO;
                ptr_s   = ptr_r + ADR_ONE;
                if (ptr_r == ADR_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_CLR;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // A command sampled while an INC or CLEAR is running is discarded.
        if ((state_r != ST_IDLE) && (cmd != CMD_NOP)) begin
            err_s = 1'b1;
        end else begin
            err_s = err_s;
        end
    end

    // FSM state, pointers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            ptr_r     <= ADR_ZERO;
            inc_adr_r <= ADR_ZERO;
            rdata_r   <= DATA_ZERO;
            rvalid_r  <= 1'b0;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            ptr_r     <= ptr_s;
            inc_adr_r <= inc_adr_s;
            rdata_r   <= rdata_s;
            rvalid_r  <= rvalid_s;
            busy_r    <= (state_s != ST_IDLE);
            err_r     <= err_s;
        end
    end

    // Register file: a single write port shared by WRITE, INC and CLEAR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= DATA_ZERO;
            end
        end else if (we_s) begin
            mem_r[wadr_s] <= wdata_s;
        end else begin
            mem_r[wadr_s] <= mem_r[wadr_s];
        end
    end

    assign rdata  = rdata_r;
    assign rvalid = rvalid_r;
    assign busy   = busy_r;
    assign err    = err_r;

`ifdef DUT_CMD_RESPONDER_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic             accept_s, drop_s;
    logic [CNT_W-1:0] cmd_count_r, drop_count_r;

    assign accept_s = (state_r == ST_IDLE) && (cmd != CMD_NOP) &&
                      (cmd <= CMD_CLEAR);
    assign drop_s   = (state_r != ST_IDLE) && (cmd != CMD_NOP);

    // Saturating statistics counters, cleared only by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_count_r  <= CNT_ZERO;
            drop_count_r <= CNT_ZERO;
        end else begin
            if (accept_s && (cmd_count_r != CNT_MAX)) begin
                cmd_count_r <= cmd_count_r + CNT_ONE;
            end else begin
                cmd_count_r <= cmd_count_r;
            end
            if (drop_s && (drop_count_r != CNT_MAX)) begin
                drop_count_r <= drop_count_r + CNT_ONE;
            end else begin
                drop_count_r <= drop_count_r;
            end
        end
    end

    assign cmd_count  = cmd_count_r;
    assign drop_count = drop_count_r;
`else
    assign cmd_count  = {CNT_W{1'b0}};
    assign drop_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_dut_cmd_responder.sv
// tb_dut_cmd_responder: directed scoreboard bench for dut_cmd_responder.
// Stimulus pushes the expected rvalid/err responses into a queue. A monitor
// that runs on the falling edge pops an entry and compares it with the DUT
// output each time rvalid or err is seen.
module tb_dut_cmd_responder;

    localparam logic [3:0] C_NOP   = 4'd0;
    localparam logic [3:0] C_WRITE = 4'd1;
    localparam logic [3:0] C_READ  = 4'd2;
    localparam logic [3:0] C_INC   = 4'd3;
    localparam logic [3:0] C_CLEAR = 4'd4;

`ifdef DUT_CMD_RESPONDER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic       is_err;
        logic [3:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cmd, adr, data;
    logic [3:0]  rdata;
    logic        rvalid, busy, err;
    logic [15:0] cmd_count, drop_count;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    dut_cmd_responder dut (
        .clk(clk), .rst(rst), .cmd(cmd), .adr(adr), .data(data),
        .rdata(rdata), .rvalid(rvalid), .busy(busy), .err(err),
        .cmd_count(cmd_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic step(input logic [3:0] c, input logic [3:0] a, input logic [3:0] d);
        @(negedge clk);
        cmd = c; adr = a; data = d;
    endtask

    task automatic exp_rd(input logic [3:0] v);
        exp_q.push_back('{is_err: 1'b0, val: v});
    endtask

    task automatic exp_err();
        exp_q.push_back('{is_err: 1'b1, val: 4'd0});
    endtask

    // Response monitor: each rvalid/err event must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && (rvalid || err)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got rvalid=%0b err=%0b rdata=%0d, expected none",
                         rvalid, err, rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_err) begin
                    if (!(err && !rvalid)) begin
                        errors++;
                        $display("FAIL err_resp: got rvalid=%0b err=%0b, expected err pulse",
                                 rvalid, err);
                    end
                end else if (!(rvalid && !err && rdata == e.val)) begin
                    errors++;
                    $display("FAIL rd_resp: got rvalid=%0b err=%0b rdata=%0d, expected rdata=%0d",
                             rvalid, err, rdata, e.val);
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cycles;
        rst = 1'b1; cmd = C_NOP; adr = 4'd0; data = 4'd0;
        #1;
        chk("rst_rdata", rdata, 0);
        chk("rst_flags", {rvalid, busy, err}, 0);
        chk("rst_cmd_count", cmd_count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // WRITE then READ on consecutive edges
        step(C_WRITE, 4'd3, 4'd9);
        step(C_READ, 4'd3, 4'd0); exp_rd(4'd9);
        step(C_NOP, 4'd0, 4'd0);
        @(posedge clk); #3;
        chk("wr_rd_cmd_count", cmd_count, STATS ? 2 : 0);

        // Asynchronous reset in mid-cycle clears the outputs with no clock edge
        rst = 1'b1;
        #1;
        chk("async_rst_rdata", rdata, 0);
        chk("async_rst_flags", {rvalid, busy, err}, 0);
        chk("async_rst_cmd_count", cmd_count, 0);
        @(negedge clk);
        rst = 1'b0;
        step(C_READ, 4'd7, 4'd0); exp_rd(4'd0);
        step(C_READ, 4'd3, 4'd0); exp_rd(4'd0);

        // INC wrap 15 -> 0, then a normal INC 4 -> 5
        step(C_WRITE, 4'd5, 4'd15);
        step(C_INC, 4'd5, 4'd0); exp_rd(4'd0);
        step(C_NOP, 4'd0, 4'd0);
        step(C_READ, 4'd5, 4'd0); exp_rd(4'd0);
        step(C_WRITE, 4'd6, 4'd4);
        step(C_INC, 4'd6, 4'd0); exp_rd(4'd5);
        step(C_NOP, 4'd0, 4'd0);
        step(C_READ, 4'd6, 4'd0); exp_rd(4'd5);
        step(C_NOP, 4'd0, 4'd0);
        chk("inc_cmd_count", cmd_count, STATS ? 8 : 0);

        // An illegal command pulses err and changes nothing
        step(4'd9, 4'd5, 4'd3); exp_err();
        step(C_NOP, 4'd0, 4'd0);
        chk("illegal_cmd_count", cmd_count, STATS ? 8 : 0);
        step(C_READ, 4'd5, 4'd0); exp_rd(4'd0);

        // CLEAR with a WRITE dropped while busy
        for (int i = 0; i < 16; i++) begin
            step(C_WRITE, 4'(i), 4'd10);
        end
        step(C_CLEAR, 4'd0, 4'd0);
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (i == 3) begin
                cmd = C_WRITE; adr = 4'd2; data = 4'd7; exp_err();
            end else begin
                cmd = C_NOP; adr = 4'd0; data = 4'd0;
            end
        end
        chk("clear_busy_cycles", busy_cycles, 16);
        chk("clear_busy_after", busy, 0);
        chk("clear_drop_count", drop_count, STATS ? 1 : 0);
        chk("clear_cmd_count", cmd_count, STATS ? 26 : 0);
        for (int i = 0; i < 16; i++) begin
            step(C_READ, 4'(i), 4'd0); exp_rd(4'd0);
        end
        step(C_NOP, 4'd0, 4'd0);
        chk("reads_cmd_count", cmd_count, STATS ? 42 : 0);

        // Reset 5 cycles into a CLEAR aborts it, and every entry reads 0
        step(C_WRITE, 4'd0, 4'd5);
        step(C_WRITE, 4'd8, 4'd6);
        step(C_WRITE, 4'd15, 4'd7);
        step(C_CLEAR, 4'd0, 4'd0);
        repeat (5) step(C_NOP, 4'd0, 4'd0);
        chk("mid_clear_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_clear_rst_busy", busy, 0);
        chk("mid_clear_rst_counts", {cmd_count, drop_count}, 0);
        @(negedge clk);
        rst = 1'b0;
        step(C_READ, 4'd0, 4'd0);  exp_rd(4'd0);
        step(C_READ, 4'd8, 4'd0);  exp_rd(4'd0);
        step(C_READ, 4'd15, 4'd0); exp_rd(4'd0);
        step(C_NOP, 4'd0, 4'd0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
